// File: rtl/lsu_dmem_if_if.sv
// Data-memory bus bundle between the load/store unit (master) and the memory (slave).
// The master drives the request, the write flag, the address, the byte enables and the write data; the slave returns the ack and the read data.
interface lsu_dmem_if_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/lsu_dmem_if.sv
// Load/store unit: turns one core memory op into one aligned req/ack bus access and stalls the core until it completes.
// Define DMEM_TIMEOUT_EN to abort a BUSY access after TIMEOUT_CYCLES without bus_ack (bus_err pulse).
module lsu_dmem_if #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_dmem_req,
    input  logic                i_dmem_wr,
    input  logic [1:0]          i_dmem_size,
    input  logic                i_dmem_zero_ex,
    input  logic [31:0]         i_addr,
    input  logic [31:0]         i_wr_data,
    output logic [31:0]         o_rd_data,
    output logic                o_stall,
    output logic                o_misalign_err,
    output logic                o_bus_err,
    lsu_dmem_if_if.master       dmem
);

    localparam logic [1:0] OP_DMEM_BYTE = 2'd0;
    localparam logic [1:0] OP_DMEM_HALF = 2'd1;
    localparam logic [1:0] OP_DMEM_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_zero_ex;
    logic [31:0] r_rd_data;
    logic        r_bus_err;

    logic        w_aligned;
    logic        w_issue;
    logic        w_ack;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    // Encoding 2'b11 is treated as a word access.
    always_comb begin
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = i_wr_data;
        case (i_dmem_size)
            OP_DMEM_BYTE: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << i_addr[1:0];
                w_wdata   = {4{i_wr_data[7:0]}};
            end
            OP_DMEM_HALF: begin
                w_aligned = ~i_addr[0];
                w_be      = 4'b0011 << i_addr[1:0];
                w_wdata   = {2{i_wr_data[15:0]}};
            end
            default: begin
                w_aligned = (i_addr[1:0] == 2'b00);
                w_be      = 4'b1111;
                w_wdata   = i_wr_data;
            end
        endcase
    end

    assign w_issue = (r_state == S_IDLE) && i_dmem_req && w_aligned;
    assign w_ack   = (r_state == S_BUSY) && dmem.bus_ack;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // The counter holds the number of BUSY cycles already spent without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= '0;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == S_BUSY) && !dmem.bus_ack &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_next = S_BUSY;
            S_BUSY:  if (w_ack || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stall is asserted in the issue cycle itself so the core holds before the bus access starts.
    always_comb begin
        o_stall        = 1'b0;
        o_misalign_err = 1'b0;
        if (!rst) begin
            o_stall        = w_issue || (r_state == S_BUSY);
            o_misalign_err = (r_state == S_IDLE) && i_dmem_req && !w_aligned;
        end
    end

    always_comb begin
        w_byte = dmem.bus_rdata[{r_lane, 3'b000} +: 8];
        w_half = dmem.bus_rdata[{r_lane[1], 4'b0000} +: 16];
        case (r_size)
            OP_DMEM_BYTE: w_ext = r_zero_ex ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            OP_DMEM_HALF: w_ext = r_zero_ex ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default:      w_ext = dmem.bus_rdata;
        endcase
    end

    // Bus fields are latched at issue so later changes on the core inputs cannot disturb the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_lane      <= '0;
            r_size      <= '0;
            r_zero_ex   <= 1'b0;
            r_rd_data   <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            if (w_issue) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= i_dmem_wr;
                r_bus_addr  <= {i_addr[31:2], 2'b00};
                r_bus_be    <= w_be;
                r_bus_wdata <= w_wdata;
                r_lane      <= i_addr[1:0];
                r_size      <= i_dmem_size;
                r_zero_ex   <= i_dmem_zero_ex;
            end
            if (w_ack || w_timeout) begin
                r_bus_req <= 1'b0;
                r_bus_err <= w_timeout;
                if (!r_bus_we) begin
                    r_rd_data <= w_ack ? w_ext : 32'h0;
                end
            end
        end
    end

    assign dmem.bus_req   = r_bus_req;
    assign dmem.bus_we    = r_bus_we;
    assign dmem.bus_addr  = r_bus_addr;
    assign dmem.bus_be    = r_bus_be;
    assign dmem.bus_wdata = r_bus_wdata;
    assign o_rd_data      = r_rd_data;
    assign o_bus_err      = r_bus_err;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Scoreboard bench for lsu_dmem_if: expected bus fields and load results are queued at issue and compared when the DUT retires the access.
module tb_lsu_dmem_if;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        dmemReq;
    logic        dmemWr;
    logic [1:0]  dmemSize;
    logic        dmemZeroEx;
    logic [31:0] addr;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic        stall;
    logic        misalignErr;
    logic        busErr;

    int          checks;
    int          errors;
    logic [31:0] lastRd;
    exp_t        sbq[$];

    lsu_dmem_if_if busIf ();

    lsu_dmem_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_dmem_req     (dmemReq),
        .i_dmem_wr      (dmemWr),
        .i_dmem_size    (dmemSize),
        .i_dmem_zero_ex (dmemZeroEx),
        .i_addr         (addr),
        .i_wr_data      (wrData),
        .o_rd_data      (rdData),
        .o_stall        (stall),
        .o_misalign_err (misalignErr),
        .o_bus_err      (busErr),
        .dmem           (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] expBe(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] expWdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: return {d[7:0], d[7:0], d[7:0], d[7:0]};
            SZ_HALF: return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] expLoad(input logic [1:0] size, input logic zex,
                                            input logic [1:0] lane, input logic [31:0] rdata);
        logic [31:0] s;
        case (size)
            SZ_BYTE: begin
                s = (rdata >> (8 * lane)) & 32'hFF;
                if (!zex && s[7]) s = s | 32'hFFFF_FF00;
            end
            SZ_HALF: begin
                s = (rdata >> (lane[1] ? 16 : 0)) & 32'hFFFF;
                if (!zex && s[15]) s = s | 32'hFFFF_0000;
            end
            default: s = rdata;
        endcase
        return s;
    endfunction

    // One complete access: issue, hold the bus for 'waits' cycles, ack, then check the DONE cycle.
    task automatic runAccess(input logic wr, input logic [1:0] size, input logic zex,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int waits, input logic [31:0] rdata, input string name);
        exp_t e;
        exp_t cur;
        int   stallCnt;
        e.we    = wr;
        e.addr  = {a[31:2], 2'b00};
        e.be    = expBe(size, a[1:0]);
        e.wdata = expWdata(size, wd);
        e.rd    = wr ? lastRd : expLoad(size, zex, a[1:0], rdata);
        lastRd  = e.rd;
        sbq.push_back(e);

        @(posedge clk); #1;
        dmemReq = 1'b1; dmemWr = wr; dmemSize = size; dmemZeroEx = zex; addr = a; wrData = wd;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || misalignErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s issue: stall=%b misalign=%b, required stall=1 misalign=0", name, stall, misalignErr);
        end
        stallCnt = 1;
        @(posedge clk); #1;
        addr = a ^ 32'h0000_0F0E; dmemWr = ~wr; wrData = ~wd;
        cur = sbq[0];
        for (int w = 0; w <= waits; w++) begin
            @(negedge clk);
            if (stall === 1'b1) stallCnt++;
            if (w == 0) begin
                checks++;
                if (busIf.bus_req !== 1'b1 || busIf.bus_we !== cur.we || busIf.bus_addr !== cur.addr ||
                    busIf.bus_be !== cur.be || busIf.bus_wdata !== cur.wdata) begin
                    errors++;
                    $display("[TB] FAIL %s bus: req=%b we=%b addr=%h be=%b wdata=%h, required req=1 we=%b addr=%h be=%b wdata=%h",
                             name, busIf.bus_req, busIf.bus_we, busIf.bus_addr, busIf.bus_be, busIf.bus_wdata,
                             cur.we, cur.addr, cur.be, cur.wdata);
                end
            end
            if (w == waits) begin
                busIf.bus_ack   = 1'b1;
                busIf.bus_rdata = rdata;
            end
            @(posedge clk); #1;
            busIf.bus_ack   = 1'b0;
            busIf.bus_rdata = $urandom;
            if (w == waits) dmemReq = 1'b0;
        end
        @(negedge clk);
        cur = sbq.pop_front();
        checks++;
        if (stall !== 1'b0 || busIf.bus_req !== 1'b0 || rdData !== cur.rd) begin
            errors++;
            $display("[TB] FAIL %s done: stall=%b req=%b rd_data=%h, required stall=0 req=0 rd_data=%h",
                     name, stall, busIf.bus_req, rdData, cur.rd);
        end
        checks++;
        if (stallCnt != waits + 2) begin
            errors++;
            $display("[TB] FAIL %s stall_len: %0d cycles, required %0d", name, stallCnt, waits + 2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dmemReq = 1'b1; dmemWr = 1'b0; dmemSize = SZ_WORD; dmemZeroEx = 1'b0;
        addr = 32'h100; wrData = 32'h0;
        busIf.bus_ack = 1'b0; busIf.bus_rdata = 32'h0;
        lastRd = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (stall !== 1'b0 || busIf.bus_req !== 1'b0 || rdData !== 32'h0 || misalignErr !== 1'b0 ||
            busErr !== 1'b0 || busIf.bus_be !== 4'h0 || busIf.bus_addr !== 32'h0 ||
            busIf.bus_wdata !== 32'h0 || busIf.bus_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: stall=%b req=%b rd=%h mis=%b berr=%b be=%b addr=%h, required all zero",
                     stall, busIf.bus_req, rdData, misalignErr, busErr, busIf.bus_be, busIf.bus_addr);
        end
        dmemReq = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_word_load();
        runAccess(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, "lw_0x100");
    endtask

    task automatic test_byte_load();
        runAccess(1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 0, 32'h80FF_0000, "lb_0x103");
        runAccess(1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 1, 32'h80FF_0000, "lbu_0x103");
    endtask

    task automatic test_store_half();
        runAccess(1'b1, SZ_HALF, 1'b0, 32'h202, 32'h1234ABCD, 3, 32'h5555_5555, "sh_0x202");
    endtask

    task automatic test_back_to_back();
        runAccess(1'b1, SZ_WORD, 1'b0, 32'h40, 32'hCAFE_F00D, 1, 32'h0, "sw_0x40");
        runAccess(1'b0, SZ_HALF, 1'b1, 32'h42, 32'h0, 0, 32'h9ABC_1234, "lhu_0x42");
        runAccess(1'b0, SZ_BYTE, 1'b0, 32'h41, 32'h0, 2, 32'h0000_7F00, "lb_0x41");
        runAccess(1'b0, SZ_HALF, 1'b0, 32'h0, 32'h0, 0, 32'h0000_8001, "lh_0x0");
        runAccess(1'b1, SZ_BYTE, 1'b0, 32'h81, 32'h0000_00A5, 0, 32'h0, "sb_0x81");
    endtask

    task automatic test_misalign();
        logic [31:0] badAddr [3];
        logic [1:0]  badSize [3];
        badAddr[0] = 32'h101; badSize[0] = SZ_WORD;
        badAddr[1] = 32'h203; badSize[1] = SZ_HALF;
        badAddr[2] = 32'h102; badSize[2] = SZ_WORD;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            dmemReq = 1'b1; dmemWr = 1'b0; dmemSize = badSize[i]; addr = badAddr[i];
            @(negedge clk);
            checks++;
            if (misalignErr !== 1'b1 || stall !== 1'b0 || busIf.bus_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL misalign_%0d: mis=%b stall=%b req=%b, required mis=1 stall=0 req=0",
                         i, misalignErr, stall, busIf.bus_req);
            end
            @(posedge clk); #1;
            dmemReq = 1'b0;
            @(negedge clk);
            checks++;
            if (misalignErr !== 1'b0 || busIf.bus_req !== 1'b0 || rdData !== lastRd) begin
                errors++;
                $display("[TB] FAIL misalign_after_%0d: mis=%b req=%b rd=%h, required mis=0 req=0 rd=%h",
                         i, misalignErr, busIf.bus_req, rdData, lastRd);
            end
        end
    endtask

    task automatic test_timeout();
        int stallHigh;
        @(posedge clk); #1;
        dmemReq = 1'b1; dmemWr = 1'b0; dmemSize = SZ_WORD; dmemZeroEx = 1'b0; addr = 32'h300;
        @(negedge clk);
        stallHigh = (stall === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        dmemReq = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (stall === 1'b1 && busErr === 1'b0 && busIf.bus_req === 1'b1) stallHigh++;
            if (c < 3) @(posedge clk);
        end
        checks++;
        if (stallHigh != 5) begin
            errors++;
            $display("[TB] FAIL timeout_busy: %0d clean stall cycles, required 5", stallHigh);
        end
        @(negedge clk);
        checks++;
        if (busErr !== 1'b1 || stall !== 1'b0 || rdData !== 32'h0 || busIf.bus_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_abort: berr=%b stall=%b rd=%h req=%b, required berr=1 stall=0 rd=0 req=0",
                     busErr, stall, rdData, busIf.bus_req);
        end
        lastRd = 32'h0;
        @(negedge clk);
        checks++;
        if (busErr !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: berr=%b stall=%b, required berr=0 stall=0", busErr, stall);
        end
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (stall === 1'b1 && busErr === 1'b0 && busIf.bus_req === 1'b1) stallHigh++;
        end
        checks++;
        if (stallHigh != 21) begin
            errors++;
            $display("[TB] FAIL no_timeout_hold: %0d clean stall cycles, required 21", stallHigh);
        end
        busIf.bus_ack   = 1'b1;
        busIf.bus_rdata = 32'h1122_3344;
        @(posedge clk); #1;
        busIf.bus_ack = 1'b0;
        @(negedge clk);
        lastRd = 32'h1122_3344;
        checks++;
        if (stall !== 1'b0 || rdData !== lastRd) begin
            errors++;
            $display("[TB] FAIL no_timeout_done: stall=%b rd=%h, required stall=0 rd=%h", stall, rdData, lastRd);
        end
`endif
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1;
        dmemReq = 1'b1; dmemWr = 1'b0; dmemSize = SZ_WORD; dmemZeroEx = 1'b0; addr = 32'h400;
        @(posedge clk); #1;
        dmemReq = 1'b0;
        @(negedge clk);
        checks++;
        if (busIf.bus_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_busy_pre: req=%b, required 1", busIf.bus_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busIf.bus_req !== 1'b0 || stall !== 1'b0 || rdData !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_busy_async: req=%b stall=%b rd=%h, required req=0 stall=0 rd=0",
                     busIf.bus_req, stall, rdData);
        end
        lastRd = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        busIf.bus_ack = 1'b1; busIf.bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (busIf.bus_req !== 1'b0 || stall !== 1'b0 || rdData !== 32'h0) begin
            errors++;
            $display("[TB] FAIL late_ack: req=%b stall=%b rd=%h, required req=0 stall=0 rd=0",
                     busIf.bus_req, stall, rdData);
        end
        @(posedge clk); #1;
        busIf.bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (rdData !== 32'h0 || busIf.bus_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_ack_after: rd=%h req=%b, required rd=0 req=0", rdData, busIf.bus_req);
        end
        runAccess(1'b0, SZ_HALF, 1'b0, 32'h2, 32'h0, 0, 32'h7FFF_0000, "lh_0x2");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_store_half();
        test_back_to_back();
        test_misalign();
        test_timeout();
        test_reset_mid_busy();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
